dsp_mac_stream: RTL and testbench
=================================

Name: dsp_mac_stream

Overview:
- Parametrised pipelined multiply-add / multiply-accumulate with three joined AXI-stream operand inputs (A, B, C) and one AXI-stream result output.
- Per-beat mode selects either result = A*B + C, or packet accumulation: sum of A*B over a tlast-delimited packet, plus C of the first beat.
- Full backpressure through the pipeline. Sits in the DSP datapath wherever a streaming MAC is needed, for example FIR taps or dot products.

Parameters:
- WIDTH, 16, operand width of A, B and C.
- ACC_WIDTH, 40, result and accumulator width; must be >= 2*WIDTH.
- PIPE_STAGES, 3, multiplier pipeline depth in cycles; must be >= 1.
- SIGNED, 1, operand interpretation: 1 = two's complement, 0 = unsigned. C is sign- or zero-extended to match.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_a_tdata  in  WIDTH  operand A
- s_a_tvalid  in  1  A valid
- s_a_tready  out  1  A ready
- s_b_tdata  in  WIDTH  operand B
- s_b_tvalid  in  1  B valid
- s_b_tready  out  1  B ready
- s_c_tdata  in  WIDTH  addend C
- s_c_tvalid  in  1  C valid
- s_c_tready  out  1  C ready
- s_acc_mode  in  1  qualifies the joined beat: 0 = multiply-add, 1 = accumulate
- s_tlast  in  1  qualifies the joined beat: last beat of an accumulate packet
- m_tdata  out  ACC_WIDTH  result
- m_tvalid  out  1  result valid
- m_tready  in  1  downstream ready
- m_tuser_ovf  out  1  overflow flag for this result

Behaviour:
- Reset: rst synchronous active-high, clock clk. After reset all stage valids = 0, accumulator = 0, accumulate-open flag = 0, m_tvalid = 0, m_tdata = 0, m_tuser_ovf = 0.
- Reset mid-operation discards in-flight beats and any open accumulation. No output is produced for them.
- Advance enable: ce = ~m_tvalid | m_tready. When ce = 0 the whole pipeline holds: no data changes and no beat is lost.
- Join:
  - s_a_tready = ce & s_b_tvalid & s_c_tvalid; B and C ready symmetrically.
  - A beat is accepted only when all three valids and ce are high. No partial consumption; a lone valid is never acked.
- Pipeline:
  - Each stage carries data, valid, mode and last.
  - Bubbles are carried as valid = 0 and do not alter stage data.
  - Product is full 2*WIDTH, extended to ACC_WIDTH per SIGNED.
- Latency: accepted beat to result visible at m_tdata/m_tvalid is exactly PIPE_STAGES+1 cycles with m_tready held high.
- Throughput: 1 beat/cycle when unstalled.
- Mode 0: m_tdata = ext(A*B) + ext(C) mod 2^ACC_WIDTH. One output per input beat. An open accumulator is untouched.
- Mode 1:
  - First beat of a packet (flag closed): acc = ext(A*B) + ext(C); flag opens.
  - Subsequent beats: acc += ext(A*B); their C is ignored.
  - A non-last beat produces no output.
  - A last beat emits acc (including its own product) and closes the flag.
  - A single-beat packet with last = 1 emits A*B+C.
- Mode-1 output and a mode-0 output never collide: one result per final-stage valid, in input order.
- Output holds m_tdata, m_tvalid and m_tuser_ovf stable while m_tvalid & ~m_tready.

Optional Feature:
- Macro DSP_MAC_SAT_EN.
- Defined: every add that overflows the signed ACC_WIDTH range (or the unsigned range when SIGNED = 0) clamps to the max/min representable value.
  - Once an accumulation saturates it stays clamped until the packet closes.
  - m_tuser_ovf = 1 on the emitted result if any clamp occurred for that result.
- Undefined: arithmetic wraps modulo 2^ACC_WIDTH and m_tuser_ovf is tied to 0.

Test Plan:
- Mode 0, WIDTH=16, SIGNED=1, m_tready=1: A=-3, B=7, C=100, one beat -> m_tdata=79, m_tvalid high exactly PIPE_STAGES+1 cycles after acceptance.
- Join: A valid only for 5 cycles, B and C late -> all treadys stay 0 until all three are valid; exactly one result.
- Backpressure: 8 back-to-back mode-0 beats (A=i, B=2, C=0), m_tready toggled 1/0 -> results 0,2,..,14 in order, none lost or duplicated, data stable while stalled.
- Accumulate: 4-beat packet A=1..4, B=10, C=5 on the first beat and 999 on later beats, last on beat 4 -> single output 105. A following mode-0 beat 2*3+1 -> 7.
- Reset at cycle 2 of an open 4-beat packet, then a 1-beat mode-1 packet A=2, B=2, C=1 -> only output 5.
- DSP_MAC_SAT_EN, ACC_WIDTH=32: accumulate 3 beats of 32767*32767 -> 0x7FFFFFFF with m_tuser_ovf=1. Same stimulus without the macro -> wrapped value (3*1073676289 mod 2^32, as signed), flag 0.

Source files
------------

// File: rtl/dsp_mac_stream_if.sv
// dsp_mac_stream_if: stream bundle for the streaming MAC.
// Carries the three joined operand streams (A, B, C), their shared beat
// qualifiers (mode, last) and the result stream with its overflow flag.
// The slave modport is the MAC's view; the master modport is the view of
// whatever feeds operands in and takes results out.

interface dsp_mac_stream_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
);
    logic [WIDTH-1:0]     s_a_tdata;
    logic                 s_a_tvalid;
    logic                 s_a_tready;
    logic [WIDTH-1:0]     s_b_tdata;
    logic                 s_b_tvalid;
    logic                 s_b_tready;
    logic [WIDTH-1:0]     s_c_tdata;
    logic                 s_c_tvalid;
    logic                 s_c_tready;
    logic                 s_acc_mode;
    logic                 s_tlast;
    logic [ACC_WIDTH-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tuser_ovf;

    modport slave (
        input  s_a_tdata, s_a_tvalid, s_b_tdata, s_b_tvalid,
        input  s_c_tdata, s_c_tvalid, s_acc_mode, s_tlast, m_tready,
        output s_a_tready, s_b_tready, s_c_tready,
        output m_tdata, m_tvalid, m_tuser_ovf
    );

    modport master (
        output s_a_tdata, s_a_tvalid, s_b_tdata, s_b_tvalid,
        output s_c_tdata, s_c_tvalid, s_acc_mode, s_tlast, m_tready,
        input  s_a_tready, s_b_tready, s_c_tready,
        input  m_tdata, m_tvalid, m_tuser_ovf
    );
endinterface

// File: rtl/dsp_mac_stream.sv
// dsp_mac_stream: pipelined multiply-add / multiply-accumulate.
// Three joined operand streams are consumed together. Per beat, mode 0
// yields A*B+C; mode 1 sums A*B over a tlast-delimited packet, seeded with
// the first beat's C. The whole pipeline stalls on a single enable
// (ce = ~m_tvalid | m_tready), so backpressure never loses a beat.
// Optional feature macro: DSP_MAC_SAT_EN -- when defined, every add clamps
// on overflow and m_tuser_ovf reports it; otherwise arithmetic wraps and
// m_tuser_ovf is always 0.

module dsp_mac_stream #(
    parameter int WIDTH       = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int PIPE_STAGES = 3,
    parameter int SIGNED      = 1
) (
    input  logic               clk,
    input  logic               rst,
    dsp_mac_stream_if.slave    bus
);
    localparam int PW  = 2 * WIDTH;
    localparam int MSB = ACC_WIDTH - 1;

`ifdef DSP_MAC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};
`endif

    // Full-width product, extended to the accumulator width.
    function automatic logic [ACC_WIDTH-1:0] ext_prod(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b);
        logic signed [PW-1:0] sp;
        logic        [PW-1:0] up;
        if (SIGNED != 0) begin
            sp = PW'($signed(a)) * PW'($signed(b));
            return ACC_WIDTH'(sp);
        end else begin
            up = PW'(a) * PW'(b);
            return ACC_WIDTH'(up);
        end
    endfunction

    // Addend extended the same way as the operands are interpreted.
    function automatic logic [ACC_WIDTH-1:0] ext_c(input logic [WIDTH-1:0] c);
        if (SIGNED != 0) begin
            return ACC_WIDTH'($signed(c));
        end else begin
            return ACC_WIDTH'(c);
        end
    endfunction

    // Add returning {overflow, sum}; clamps only when saturation is built in.
    function automatic logic [ACC_WIDTH:0] add_chk(input logic [ACC_WIDTH-1:0] x,
                                                    input logic [ACC_WIDTH-1:0] y);
        logic [ACC_WIDTH:0] wide;
        wide = {1'b0, x} + {1'b0, y};
`ifdef DSP_MAC_SAT_EN
        if (SIGNED != 0) begin
            if ((x[MSB] == y[MSB]) && (wide[MSB] != x[MSB])) begin
                return {1'b1, (x[MSB] ? SMIN : SMAX)};
            end else begin
                return {1'b0, wide[ACC_WIDTH-1:0]};
            end
        end else begin
            if (wide[ACC_WIDTH]) begin
                return {1'b1, UMAX};
            end else begin
                return {1'b0, wide[ACC_WIDTH-1:0]};
            end
        end
`else
        return {1'b0, wide[ACC_WIDTH-1:0]};
`endif
    endfunction

    // Stage 0 holds the accepted operands; stages 1..PIPE_STAGES hold the product.
    logic                  s0_valid_r, s0_mode_r, s0_last_r;
    logic [WIDTH-1:0]      s0_a_r, s0_b_r;
    logic [ACC_WIDTH-1:0]  s0_c_r;
    logic [PIPE_STAGES-1:0] pv_r, pm_r, pl_r;
    logic [ACC_WIDTH-1:0]  pp_r [PIPE_STAGES];
    logic [ACC_WIDTH-1:0]  pc_r [PIPE_STAGES];

    // Output and accumulator state.
    logic [ACC_WIDTH-1:0]  m_tdata_r;
    logic                  m_tvalid_r;
    logic                  m_ovf_r;
    logic [ACC_WIDTH-1:0]  acc_r;
    logic                  acc_open_r;
    logic                  acc_ovf_r;

    logic                  ce_s;
    logic                  accept_s;
    logic                  fin_valid_s, fin_mode_s, fin_last_s;
    logic [ACC_WIDTH-1:0]  fin_prod_s, fin_c_s;
    logic [ACC_WIDTH-1:0]  base_s, sum_s;
    logic [ACC_WIDTH:0]    add_s;
    logic                  ovf_s;

    assign ce_s     = ~m_tvalid_r | bus.m_tready;
    assign accept_s = ce_s & bus.s_a_tvalid & bus.s_b_tvalid & bus.s_c_tvalid;

    assign bus.s_a_tready = ce_s & bus.s_b_tvalid & bus.s_c_tvalid;
    assign bus.s_b_tready = ce_s & bus.s_a_tvalid & bus.s_c_tvalid;
    assign bus.s_c_tready = ce_s & bus.s_a_tvalid & bus.s_b_tvalid;

    assign bus.m_tdata     = m_tdata_r;
    assign bus.m_tvalid    = m_tvalid_r;
    assign bus.m_tuser_ovf = m_ovf_r;

    assign fin_valid_s = pv_r[PIPE_STAGES-1];
    assign fin_mode_s  = pm_r[PIPE_STAGES-1];
    assign fin_last_s  = pl_r[PIPE_STAGES-1];
    assign fin_prod_s  = pp_r[PIPE_STAGES-1];
    assign fin_c_s     = pc_r[PIPE_STAGES-1];

    // Operand capture and product pipeline; data moves only with a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_r <= 1'b0;
            s0_mode_r  <= 1'b0;
            s0_last_r  <= 1'b0;
            s0_a_r     <= {WIDTH{1'b0}};
            s0_b_r     <= {WIDTH{1'b0}};
            s0_c_r     <= {ACC_WIDTH{1'b0}};
            pv_r       <= {PIPE_STAGES{1'b0}};
            pm_r       <= {PIPE_STAGES{1'b0}};
            pl_r       <= {PIPE_STAGES{1'b0}};
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pp_r[i] <= {ACC_WIDTH{1'b0}};
                pc_r[i] <= {ACC_WIDTH{1'b0}};
            end
        end else if (ce_s) begin
            s0_valid_r <= accept_s;
            if (accept_s) begin
                s0_a_r    <= bus.s_a_tdata;
                s0_b_r    <= bus.s_b_tdata;
                s0_c_r    <= ext_c(bus.s_c_tdata);
                s0_mode_r <= bus.s_acc_mode;
                s0_last_r <= bus.s_tlast;
            end
            pv_r[0] <= s0_valid_r;
            if (s0_valid_r) begin
                pp_r[0] <= ext_prod(s0_a_r, s0_b_r);
                pc_r[0] <= s0_c_r;
                pm_r[0] <= s0_mode_r;
                pl_r[0] <= s0_last_r;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pv_r[i] <= pv_r[i-1];
                if (pv_r[i-1]) begin
                    pp_r[i] <= pp_r[i-1];
                    pc_r[i] <= pc_r[i-1];
                    pm_r[i] <= pm_r[i-1];
                    pl_r[i] <= pl_r[i-1];
                end
            end
        end
    end

    // Final add: C seeds mode-0 beats and packet openers, acc otherwise;
    // a clamped accumulation stays pinned until its packet closes.
    always_comb begin
        base_s = fin_c_s;
        if (fin_mode_s && acc_open_r) begin
            base_s = acc_r;
        end else begin
            base_s = fin_c_s;
        end
        add_s = add_chk(base_s, fin_prod_s);
        if (fin_mode_s && acc_open_r && acc_ovf_r) begin
            sum_s = acc_r;
            ovf_s = 1'b1;
        end else begin
            sum_s = add_s[ACC_WIDTH-1:0];
            ovf_s = add_s[ACC_WIDTH];
        end
    end

    // Result register and packet accumulator; holds everything while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_tdata_r  <= {ACC_WIDTH{1'b0}};
            m_tvalid_r <= 1'b0;
            m_ovf_r    <= 1'b0;
            acc_r      <= {ACC_WIDTH{1'b0}};
            acc_open_r <= 1'b0;
            acc_ovf_r  <= 1'b0;
        end else if (ce_s) begin
            if (fin_valid_s) begin
                if (!fin_mode_s) begin
                    m_tdata_r  <= sum_s;
                    m_tvalid_r <= 1'b1;
                    m_ovf_r    <= ovf_s;
                end else if (fin_last_s) begin
                    m_tdata_r  <= sum_s;
                    m_tvalid_r <= 1'b1;
                    m_ovf_r    <= ovf_s;
                    acc_r      <= {ACC_WIDTH{1'b0}};
                    acc_open_r <= 1'b0;
                    acc_ovf_r  <= 1'b0;
                end else begin
                    acc_r      <= sum_s;
                    acc_open_r <= 1'b1;
                    acc_ovf_r  <= ovf_s;
                    m_tvalid_r <= 1'b0;
                end
            end else begin
                m_tvalid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_stream.sv
// Directed bench for dsp_mac_stream (WIDTH=16, ACC_WIDTH=32, PIPE_STAGES=3).
// Inputs change on the falling edge; a monitor samples 1 time unit before
// each rising edge and records every result handshake.

module tb_dsp_mac_stream;
    localparam int W  = 16;
    localparam int AW = 32;
    localparam int P  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [AW-1:0] res_q [$];
    logic          ovf_q [$];
    int            cyc_q [$];
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_data = '0;
    logic          prev_ovf = 1'b0;

    dsp_mac_stream_if #(.WIDTH(W), .ACC_WIDTH(AW)) bus ();

    dsp_mac_stream #(.WIDTH(W), .ACC_WIDTH(AW), .PIPE_STAGES(P), .SIGNED(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: collect results and check that a stalled output holds still.
    always @(negedge clk) begin
        #4;
        if (prev_stall) begin
            checks++;
            if (bus.m_tdata !== prev_data || bus.m_tvalid !== 1'b1 || bus.m_tuser_ovf !== prev_ovf) begin
                errors++;
                $display("FAIL stall_hold: got data=%0h valid=%b, required data=%0h valid=1",
                         bus.m_tdata, bus.m_tvalid, prev_data);
            end
        end
        if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
            res_q.push_back(bus.m_tdata);
            ovf_q.push_back(bus.m_tuser_ovf);
            cyc_q.push_back(cyc);
        end
        prev_stall = (bus.m_tvalid === 1'b1) && (bus.m_tready === 1'b0);
        prev_data  = bus.m_tdata;
        prev_ovf   = bus.m_tuser_ovf;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_q();
        res_q.delete();
        ovf_q.delete();
        cyc_q.delete();
    endtask

    task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                              input logic mode, input logic last, output int acc_cyc);
        int n;
        @(negedge clk);
        bus.s_a_tdata  = a;
        bus.s_b_tdata  = b;
        bus.s_c_tdata  = c;
        bus.s_acc_mode = mode;
        bus.s_tlast    = last;
        bus.s_a_tvalid = 1'b1;
        bus.s_b_tvalid = 1'b1;
        bus.s_c_tvalid = 1'b1;
        #1;
        n = 0;
        while (bus.s_a_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no s_a_tready, required s_a_tready=1");
        end
        acc_cyc = cyc + 1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.s_a_tvalid = 1'b0;
        bus.s_b_tvalid = 1'b0;
        bus.s_c_tvalid = 1'b0;
        bus.s_tlast    = 1'b0;
        bus.s_acc_mode = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (res_q.size() < n && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", bus.m_tvalid); end
        checks++;
        if (bus.m_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata: got %0h, required 0", bus.m_tdata); end
        checks++;
        if (bus.m_tuser_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", bus.m_tuser_ovf); end
        checks++;
        if (bus.s_a_tready !== 1'b0) begin errors++; $display("FAIL reset_aready: got %b, required 0", bus.s_a_tready); end
    endtask

    task automatic test_mode0();
        int ac;
        clear_q();
        drive_beat(16'hFFFD, 16'd7, 16'd100, 1'b0, 1'b0, ac);
        idle();
        wait_results(1);
        checks++;
        if (res_q.size() != 1) begin
            errors++; $display("FAIL mode0_count: got %0d, required 1", res_q.size());
        end else begin
            checks++;
            if (res_q[0] !== 32'd79) begin errors++; $display("FAIL mode0_data: got %0d, required 79", res_q[0]); end
            checks++;
            if (cyc_q[0] - ac != P + 1) begin errors++; $display("FAIL mode0_latency: got %0d, required %0d", cyc_q[0] - ac, P + 1); end
            checks++;
            if (ovf_q[0] !== 1'b0) begin errors++; $display("FAIL mode0_ovf: got %b, required 0", ovf_q[0]); end
        end
    endtask

    task automatic test_join();
        logic ready_seen;
        int   n;
        clear_q();
        ready_seen = 1'b0;
        @(negedge clk);
        bus.s_a_tdata  = 16'd5;
        bus.s_b_tdata  = 16'd6;
        bus.s_c_tdata  = 16'd7;
        bus.s_acc_mode = 1'b0;
        bus.s_tlast    = 1'b0;
        bus.s_a_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            ready_seen = ready_seen | bus.s_a_tready | bus.s_b_tready | bus.s_c_tready;
            @(negedge clk);
        end
        checks++;
        if (ready_seen !== 1'b0) begin errors++; $display("FAIL join_lone_ready: got 1, required 0"); end
        bus.s_b_tvalid = 1'b1;
        bus.s_c_tvalid = 1'b1;
        #1;
        n = 0;
        while (bus.s_a_tready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        idle();
        wait_results(1);
        checks++;
        if (res_q.size() != 1) begin
            errors++; $display("FAIL join_count: got %0d, required 1", res_q.size());
        end else begin
            checks++;
            if (res_q[0] !== 32'd37) begin errors++; $display("FAIL join_data: got %0d, required 37", res_q[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int ac;
        logic [AW-1:0] exp_v [3];
        exp_v[0] = 32'h3FFF_FFFF;
        exp_v[1] = 32'hC000_8000;
        exp_v[2] = 32'd2;
        clear_q();
        drive_beat(16'h8000, 16'h8000, 16'hFFFF, 1'b0, 1'b0, ac);
        drive_beat(16'h7FFF, 16'h8000, 16'h0000, 1'b0, 1'b0, ac);
        drive_beat(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, ac);
        idle();
        wait_results(3);
        checks++;
        if (res_q.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d, required 3", res_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (res_q[i] !== exp_v[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %0h, required %0h", i, res_q[i], exp_v[i]); end
            end
            checks++;
            if (cyc_q[1] - cyc_q[0] != 1) begin errors++; $display("FAIL b2b_throughput: got gap %0d, required 1", cyc_q[1] - cyc_q[0]); end
        end
    endtask

    task automatic test_backpressure();
        int ac;
        clear_q();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    drive_beat(W'(i), 16'd2, 16'd0, 1'b0, 1'b0, ac);
                end
                idle();
            end
            begin
                repeat (50) begin
                    @(negedge clk);
                    bus.m_tready = ~bus.m_tready;
                end
                @(negedge clk);
                bus.m_tready = 1'b1;
            end
        join
        wait_results(8);
        checks++;
        if (res_q.size() != 8) begin
            errors++; $display("FAIL bp_count: got %0d, required 8", res_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (res_q[i] !== AW'(2 * i)) begin errors++; $display("FAIL bp_data[%0d]: got %0d, required %0d", i, res_q[i], 2 * i); end
            end
        end
    endtask

    task automatic test_accumulate();
        int ac;
        clear_q();
        drive_beat(16'd1, 16'd10, 16'd5,   1'b1, 1'b0, ac);
        drive_beat(16'd2, 16'd10, 16'd999, 1'b1, 1'b0, ac);
        drive_beat(16'd3, 16'd10, 16'd999, 1'b1, 1'b0, ac);
        drive_beat(16'd4, 16'd10, 16'd999, 1'b1, 1'b1, ac);
        drive_beat(16'd2, 16'd3,  16'd1,   1'b0, 1'b0, ac);
        idle();
        wait_results(2);
        checks++;
        if (res_q.size() != 2) begin
            errors++; $display("FAIL acc_count: got %0d, required 2", res_q.size());
        end else begin
            checks++;
            if (res_q[0] !== 32'd105) begin errors++; $display("FAIL acc_data: got %0d, required 105", res_q[0]); end
            checks++;
            if (res_q[1] !== 32'd7) begin errors++; $display("FAIL acc_then_mode0: got %0d, required 7", res_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int ac;
        clear_q();
        drive_beat(16'd1, 16'd1, 16'd1, 1'b1, 1'b0, ac);
        drive_beat(16'd1, 16'd1, 16'd1, 1'b1, 1'b0, ac);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b, required 0", bus.m_tvalid); end
        drive_beat(16'd2, 16'd2, 16'd1, 1'b1, 1'b1, ac);
        idle();
        wait_results(1);
        checks++;
        if (res_q.size() != 1) begin
            errors++; $display("FAIL midrst_count: got %0d, required 1", res_q.size());
        end else begin
            checks++;
            if (res_q[0] !== 32'd5) begin errors++; $display("FAIL midrst_data: got %0d, required 5", res_q[0]); end
        end
    endtask

    task automatic test_saturation();
        int ac;
        logic [AW-1:0] exp_d;
        logic          exp_o;
`ifdef DSP_MAC_SAT_EN
        exp_d = 32'h7FFF_FFFF;
        exp_o = 1'b1;
`else
        exp_d = 32'hBFFD_0003;
        exp_o = 1'b0;
`endif
        clear_q();
        drive_beat(16'h7FFF, 16'h7FFF, 16'd0, 1'b1, 1'b0, ac);
        drive_beat(16'h7FFF, 16'h7FFF, 16'd0, 1'b1, 1'b0, ac);
        drive_beat(16'h7FFF, 16'h7FFF, 16'd0, 1'b1, 1'b1, ac);
        idle();
        wait_results(1);
        checks++;
        if (res_q.size() != 1) begin
            errors++; $display("FAIL sat_count: got %0d, required 1", res_q.size());
        end else begin
            checks++;
            if (res_q[0] !== exp_d) begin errors++; $display("FAIL sat_data: got %0h, required %0h", res_q[0], exp_d); end
            checks++;
            if (ovf_q[0] !== exp_o) begin errors++; $display("FAIL sat_ovf: got %b, required %b", ovf_q[0], exp_o); end
        end
    endtask

    initial begin
        bus.s_a_tdata  = '0;
        bus.s_b_tdata  = '0;
        bus.s_c_tdata  = '0;
        bus.s_a_tvalid = 1'b0;
        bus.s_b_tvalid = 1'b0;
        bus.s_c_tvalid = 1'b0;
        bus.s_acc_mode = 1'b0;
        bus.s_tlast    = 1'b0;
        bus.m_tready   = 1'b1;
        test_reset();
        test_mode0();
        test_join();
        test_back_to_back();
        test_backpressure();
        test_accumulate();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
